// File: rtl/spatz_pkg.sv
// Shared VRF types and default sizing for the Spatz VRF responder and its initiators.
package spatz_pkg;

    localparam int unsigned NrVRFWords   = 128;
    localparam int unsigned NrVRFBanks   = 4;
    localparam int unsigned VRFWordWidth = 64;
    localparam int unsigned VRFAddrWidth = $clog2(NrVRFWords);
    localparam int unsigned NrWrPorts    = 3;
    localparam int unsigned NrRdPorts    = 3;

    typedef logic [VRFAddrWidth-1:0]   vreg_addr_t;
    typedef logic [VRFWordWidth-1:0]   vreg_data_t;
    typedef logic [VRFWordWidth/8-1:0] vreg_be_t;

    // Requester binding: index of each execution unit on the VRF port vectors.
    typedef enum logic [1:0] {
        VFU   = 2'd0,
        VLSU  = 2'd1,
        VSLDU = 2'd2
    } vrf_port_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spatz_vrf_bank_rr_arb.sv
// N-input round-robin arbiter: one-hot grant searched from the pointer, pointer
// moves just past the winner whenever a grant is issued and advance_i is high.
module spatz_vrf_bank_rr_arb
    import spatz_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned IdxW = idx_width(N);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] sel;
    logic            found;

    always_comb begin
        int unsigned idx;
        gnt_o = '0;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[IdxW'(idx)]) begin
                found = 1'b1;
                sel   = IdxW'(idx);
            end
        end
        if (found) gnt_o[sel] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (32'(sel) == N - 1) ? '0 : sel + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/spatz_vrf_responder.sv
// Banked flop-array VRF with per-bank round-robin write/read arbitration and
// same-cycle handshakes; reads are combinational and see pre-write contents.
module spatz_vrf_responder
    import spatz_pkg::*;
#(
    parameter int unsigned NrWords   = spatz_pkg::NrVRFWords,
    parameter int unsigned NrBanks   = spatz_pkg::NrVRFBanks,
    parameter int unsigned DataWidth = spatz_pkg::VRFWordWidth,
    parameter int unsigned NrWrPorts = spatz_pkg::NrWrPorts,
    parameter int unsigned NrRdPorts = spatz_pkg::NrRdPorts,
    parameter int unsigned AddrWidth = $clog2(NrWords)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NrWrPorts-1:0]           we_i,
    input  logic [NrWrPorts*AddrWidth-1:0] waddr_i,
    input  logic [NrWrPorts*DataWidth-1:0] wdata_i,
    input  logic [NrWrPorts*DataWidth/8-1:0] wbe_i,
    output logic [NrWrPorts-1:0]           wvalid_o,
    input  logic [NrRdPorts-1:0]           re_i,
    input  logic [NrRdPorts*AddrWidth-1:0] raddr_i,
    output logic [NrRdPorts*DataWidth-1:0] rdata_o,
    output logic [NrRdPorts-1:0]           rvalid_o
);

    localparam int unsigned BankW  = $clog2(NrBanks);
    localparam int unsigned RowW   = AddrWidth - BankW;
    localparam int unsigned NrRows = NrWords / NrBanks;
    localparam int unsigned BeW    = DataWidth / 8;

    logic [NrWrPorts-1:0][BankW-1:0] wr_bank;
    logic [NrWrPorts-1:0][RowW-1:0]  wr_row;
    logic [NrWrPorts-1:0]            wr_in_range;
    logic [NrRdPorts-1:0][BankW-1:0] rd_bank;
    logic [NrRdPorts-1:0][RowW-1:0]  rd_row;
    logic [NrRdPorts-1:0]            rd_in_range;

    logic [NrBanks-1:0][NrWrPorts-1:0] wr_req, wr_gnt;
    logic [NrBanks-1:0][NrRdPorts-1:0] rd_req, rd_gnt;

    logic [NrBanks-1:0]                bank_we;
    logic [NrBanks-1:0][RowW-1:0]      bank_wrow;
    logic [NrBanks-1:0][DataWidth-1:0] bank_wdata;
    logic [NrBanks-1:0][BeW-1:0]       bank_wbe;
    logic [NrBanks-1:0][DataWidth-1:0] bank_wmask;
    logic [NrBanks-1:0]                bank_rvld;
    logic [NrBanks-1:0][RowW-1:0]      bank_rrow;
    logic [NrBanks-1:0][DataWidth-1:0] bank_rdata;

    genvar gi, gj;

    // Rows beyond NrRows only exist when NrWords is not a power of two.
    for (gi = 0; gi < NrWrPorts; gi++) begin : g_wr_dec
        assign wr_bank[gi] = waddr_i[gi*AddrWidth +: BankW];
        assign wr_row[gi]  = waddr_i[gi*AddrWidth+BankW +: RowW];
        if (NrRows >= (1 << RowW)) begin : g_full
            assign wr_in_range[gi] = 1'b1;
        end else begin : g_part
            assign wr_in_range[gi] = (32'(wr_row[gi]) < NrRows);
        end
    end

    for (gi = 0; gi < NrRdPorts; gi++) begin : g_rd_dec
        assign rd_bank[gi] = raddr_i[gi*AddrWidth +: BankW];
        assign rd_row[gi]  = raddr_i[gi*AddrWidth+BankW +: RowW];
        if (NrRows >= (1 << RowW)) begin : g_full
            assign rd_in_range[gi] = 1'b1;
        end else begin : g_part
            assign rd_in_range[gi] = (32'(rd_row[gi]) < NrRows);
        end
    end

    for (gi = 0; gi < NrBanks; gi++) begin : g_bank
        for (gj = 0; gj < NrWrPorts; gj++) begin : g_wreq
            assign wr_req[gi][gj] = we_i[gj] && (wr_bank[gj] == BankW'(gi));
        end
        for (gj = 0; gj < NrRdPorts; gj++) begin : g_rreq
            assign rd_req[gi][gj] = re_i[gj] && (rd_bank[gj] == BankW'(gi));
        end
        for (gj = 0; gj < BeW; gj++) begin : g_mask
            assign bank_wmask[gi][gj*8 +: 8] = {8{bank_wbe[gi][gj]}};
        end

        spatz_vrf_bank_rr_arb #(.N(NrWrPorts)) i_wr_arb (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .req_i     (wr_req[gi]),
            .advance_i (1'b1),
            .gnt_o     (wr_gnt[gi])
        );

        spatz_vrf_bank_rr_arb #(.N(NrRdPorts)) i_rd_arb (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .req_i     (rd_req[gi]),
            .advance_i (1'b1),
            .gnt_o     (rd_gnt[gi])
        );

        logic [DataWidth-1:0] mem_q [NrRows];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int r = 0; r < NrRows; r++) mem_q[RowW'(r)] <= '0;
            end else if (bank_we[gi]) begin
                mem_q[bank_wrow[gi]] <= (mem_q[bank_wrow[gi]] & ~bank_wmask[gi])
                                      | (bank_wdata[gi] & bank_wmask[gi]);
            end
        end

        assign bank_rdata[gi] = bank_rvld[gi] ? mem_q[bank_rrow[gi]] : '0;
    end

    // One-hot grants make these OR-style muxes: at most one port per bank wins.
    always_comb begin
        bank_we    = '0;
        bank_wrow  = '0;
        bank_wdata = '0;
        bank_wbe   = '0;
        bank_rvld  = '0;
        bank_rrow  = '0;
        for (int b = 0; b < NrBanks; b++) begin
            for (int p = 0; p < NrWrPorts; p++) begin
                if (wr_gnt[b][p]) begin
                    bank_we[b]    = wr_in_range[p];
                    bank_wrow[b]  = wr_row[p];
                    bank_wdata[b] = wdata_i[p*DataWidth +: DataWidth];
                    bank_wbe[b]   = wbe_i[p*BeW +: BeW];
                end
            end
            for (int p = 0; p < NrRdPorts; p++) begin
                if (rd_gnt[b][p]) begin
                    bank_rvld[b] = rd_in_range[p];
                    bank_rrow[b] = rd_row[p];
                end
            end
        end
    end

    always_comb begin
        wvalid_o = '0;
        rvalid_o = '0;
        rdata_o  = '0;
        if (rst_ni) begin
            for (int b = 0; b < NrBanks; b++) begin
                wvalid_o = wvalid_o | wr_gnt[b];
                rvalid_o = rvalid_o | rd_gnt[b];
                for (int p = 0; p < NrRdPorts; p++) begin
                    if (rd_gnt[b][p]) rdata_o[p*DataWidth +: DataWidth] = bank_rdata[b];
                end
            end
        end
    end

endmodule

// File: doc/spatz_vrf_responder.md
Name: spatz_vrf_responder

Overview:
Responder (VRF side) of the VRF port protocol that VSLDU/VFU/VLSU use as initiators: requesters drive re/raddr and we/waddr/wdata/wbe, and receive rvalid/rdata and wvalid back. The block holds the vector register file as a banked flop array. It arbitrates concurrent requesters per bank with round-robin fairness and returns handshakes in the same cycle. It sits between spatz_controller's execution units and storage, replacing direct VRF hookup.

Parameters:
NrWords, 128, total VRF words (32 vregs x NrWordsPerVector=4)
NrBanks, 4, banks; power of 2; bank = addr[$clog2(NrBanks)-1:0]
DataWidth, 64, word width in bits (VRFWordWidth)
NrWrPorts, 3, write requesters
NrRdPorts, 3, read requesters
AddrWidth, $clog2(NrWords), word address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
we_i  in  NrWrPorts  write request per port
waddr_i  in  NrWrPorts x AddrWidth  word address
wdata_i  in  NrWrPorts x DataWidth  write data
wbe_i  in  NrWrPorts x DataWidth/8  byte enables
wvalid_o  out  NrWrPorts  write accepted (commits at next posedge)
re_i  in  NrRdPorts  read request per port
raddr_i  in  NrRdPorts x AddrWidth  word address
rdata_o  out  NrRdPorts x DataWidth  read data, valid with rvalid_o
rvalid_o  out  NrRdPorts  read served this cycle

Behaviour:
- Reset (async, rst_ni=0): all words = 0, all RR pointers = 0. wvalid_o/rvalid_o are combinational from requests; rdata_o = 0 when rvalid_o=0.
- Row = addr >> $clog2(NrBanks). Per bank: one write and one read granted per cycle. Writes to different banks proceed in parallel.
- Write arbitration per bank: among ports with we_i and matching bank, round-robin from wr_ptr[bank]. The granted port sees wvalid_o=1 in the same cycle. At posedge, bytes with wbe=1 are updated. Then wr_ptr[bank] = granted+1 mod NrWrPorts. Pointer holds if no grant.
- Read arbitration per bank: same scheme with rd_ptr[bank]. rvalid_o=1 in the same cycle, and rdata_o = current array contents (zero-latency, combinational read).
- Ungranted requesters see valid=0 and must hold the request. No request is dropped; a starved port is served within NrPorts-1 grants to its bank.
- Read/write same address same cycle: the read returns the pre-write data. The new data is visible from the next cycle.
- Grant is a function of the current inputs only. The requester may change its address after a grant.
- wbe_i all zero with we_i: the request is granted and the array is unchanged.
- Address with row >= NrWords/NrBanks: the request is granted; a write is dropped and a read returns 0.
- Reset mid-operation: pending requests are abandoned and the array is cleared. The initiator must re-issue after reset deassertion.
- No X on outputs for any input combination; unused rdata lanes are driven to 0.

Decomposition:
- spatz_pkg: vreg_addr_t, vreg_data_t, vreg_be_t, NrVRFBanks, NrWrPorts/NrRdPorts, and a port-index enum (VFU, VLSU, VSLDU) used to bind requesters.
- Sub-module spatz_vrf_bank_rr_arb: parameterised N-input round-robin arbiter with req vector, pointer register, one-hot gnt, and an advance-on-grant input.
- Top level: NrBanks x 2 instances plus the flop array.

Test Plan:
- Reset then read word 5 from port0 -> rvalid_o[0]=1 same cycle, rdata_o[0]=0.
- Port1 writes addr 9, data 0x1122334455667788, wbe 0x0F -> wvalid_o[1]=1. Next cycle, read of 9 returns 0x0000000055667788.
- Ports 0,1,2 all write bank 1 (addrs 1,5,9) held 3 cycles -> grants in order 0,1,2, exactly one per cycle, and all three words are written.
- Port0 writes addr 4 = 0xAA.. while port1 reads addr 4 same cycle -> read returns old value. A read of addr 4 the following cycle returns 0xAA...
- Ports 0 and 1 write addrs 0 and 1 (different banks) -> both wvalid_o=1 in the same cycle.
- Assert rst_ni=0 asynchronously after writing addr 3 -> all outputs drop immediately. After release, a read of addr 3 returns 0 and the RR order restarts at port0.
